irq_capture_prio4: RTL



---
 rtl/irq_capture_prio4.sv | 105 ++++++++++
 1 files changed

// File: rtl/irq_capture_prio4.sv
// Four-line request capture with a fixed-priority (3 highest) valid/ready index output.
// Optional IRQ_CAPTURE_MASK_EN adds a per-line mask that only affects eligibility.
module irq_capture_prio4 #(
    parameter int EDGE_MODE = 1,
    parameter int OVF_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
`ifdef IRQ_CAPTURE_MASK_EN
    input  logic [3:0]       mask,
`endif
    input  logic             out_ready,
    output logic             out_valid,
    output logic [1:0]       out_idx,
    output logic [3:0]       pending,
    output logic [OVF_W-1:0] ovf_cnt
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       pend_q, pend_d;
    logic [3:0]       req_prev_q;
    logic [OVF_W-1:0] ovf_q, ovf_d;

    logic             acc;
    logic [3:0]       ev, clr, elig, lost, mask_eff;

`ifdef IRQ_CAPTURE_MASK_EN
    assign mask_eff = mask;
`else
    assign mask_eff = 4'b0000;
`endif

    function automatic logic [1:0] top_bit(input logic [3:0] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
    always_comb begin
        ev      = (EDGE_MODE != 0) ? (req & ~req_prev_q) : req;
        acc     = (state_q == S_VALID) && out_ready;
        clr     = acc ? (4'b0001 << idx_q) : 4'b0000;
        elig    = pend_q & ~clr & ~mask_eff;
        lost    = ev & pend_q & ~clr;
        pend_d  = (pend_q & ~clr) | ev;
        ovf_d   = ovf_q;
        state_d = state_q;
        idx_d   = idx_q;

        if ((|lost) && (ovf_q != {OVF_W{1'b1}}))
            ovf_d = ovf_q + OVF_W'(1);

        case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    state_d = S_VALID;
                    idx_d   = top_bit(elig);
                end
            end
            S_VALID: begin
                // The presented index is frozen until accepted, even if a higher line arrives.
                if (acc) begin
                    if (|elig) begin
                        idx_d = top_bit(elig);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            pend_q     <= 4'b0000;
            req_prev_q <= 4'b0000;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            req_prev_q <= req;
            ovf_q      <= ovf_d;
        end
    end

    assign out_valid = (state_q == S_VALID);
    assign out_idx   = idx_q;
    assign pending   = pend_q;
    assign ovf_cnt   = ovf_q;

endmodule
